// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory that freezes the pipeline for LATENCY cycles per access
// Ports: clk_i/rst_i clock and synchronous active-high reset; addr_i, write_data_i, MemRead_i,
// MemWrite_i request from EX/MEM; data_o load result; stall_o pipeline freeze; err_o misaligned pulse.
// Option: define DMEM_POSTED_WRITE_EN to post aligned stores through a one-entry write buffer.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
`ifdef DMEM_POSTED_WRITE_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d, act_addr;
    logic [31:0]   wdata_q, wdata_d, data_q, data_d, act_data;
    logic          wr_q, wr_d, err_q, err_d;
    logic          req, post, fin, drain_done, act_wr, mis, mem_we;
    logic          unused_addr;
    logic [31:0]   mem [DEPTH_WORDS];
    assign unused_addr = ^addr_i[31:AW+2];
    assign req = MemRead_i | MemWrite_i;
    // In IDLE the access is described by the live inputs, afterwards by the captured copy.
    assign act_addr = (state_q == IDLE) ? addr_i[AW+1:0] : addr_q;
    assign act_data = (state_q == IDLE) ? write_data_i : wdata_q;
    assign act_wr   = (state_q == IDLE) ? MemWrite_i : wr_q;
    assign mis      = act_addr[1:0] != 2'b00;
`ifdef DMEM_POSTED_WRITE_EN
    assign post       = (state_q == IDLE) && MemWrite_i && !mis;
    assign drain_done = (state_q == DRAIN) && (cnt_q == '0);
`else
    assign post       = 1'b0;
    assign drain_done = 1'b0;
`endif
    // fin marks the edge that enters DONE; the memory action happens on it.
    assign fin    = ((state_q == IDLE) && req && !post && (LATENCY == 1)) ||
                    ((state_q == BUSY) && (cnt_q == CW'(1)));
    assign mem_we = (fin && act_wr && !mis) || drain_done;
    assign data_d = (fin && !act_wr) ? (mis ? 32'h0 : mem[act_addr[AW+1:2]]) : data_q;
    assign err_d  = fin && mis;
    assign data_o = data_q;
    assign err_o  = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Reset discards an in-flight store, so the array is gated by rst_i as well.
    always_ff @(posedge clk_i)
        if (mem_we && !rst_i) mem[act_addr[AW+1:2]] <= act_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: if (req) begin
                addr_d  = addr_i[AW+1:0];
                wdata_d = write_data_i;
                wr_d    = MemWrite_i;
                cnt_d   = CW'(LATENCY - 1);
                state_d = (LATENCY == 1) ? DONE : BUSY;
`ifdef DMEM_POSTED_WRITE_EN
                if (post) state_d = DRAIN;
`endif
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
`ifdef DMEM_POSTED_WRITE_EN
            DRAIN: begin
                if (cnt_q == '0) state_d = IDLE;
                else cnt_d = cnt_q - CW'(1);
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            IDLE:    stall_o = req && !post;
            BUSY:    stall_o = 1'b1;
`ifdef DMEM_POSTED_WRITE_EN
            DRAIN:   stall_o = req;
`endif
            default: stall_o = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder at LATENCY=3
module tb_dmem_responder;
    logic        clk = 1'b0, rst_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0;
    logic [31:0] addr_i = '0, write_data_i = '0, data_o;
    logic        stall_o, err_o;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
        .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .write_data_i(write_data_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .data_o(data_o),
        .stall_o(stall_o), .err_o(err_o)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        int          st;
        logic [31:0] dat;
        logic        err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input vec_t v);
        int st = 0;
        int early = 0;
        @(posedge clk); #1;
        MemRead_i = v.rd; MemWrite_i = v.wr; addr_i = v.a; write_data_i = v.d;
        @(negedge clk);
        while (stall_o === 1'b1 && st < 20) begin
            st++;
            if (err_o !== 1'b0) early++;
            @(negedge clk);
        end
        chk({v.name, " stalls"}, 32'(st), 32'(v.st));
        chk({v.name, " data"}, data_o, v.dat);
        chk({v.name, " err"}, {31'b0, err_o}, {31'b0, v.err});
        chk({v.name, " early err"}, 32'(early), 32'd0);
        @(posedge clk); #1;
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
        @(negedge clk);
        chk({v.name, " err clears"}, {31'b0, err_o}, 32'd0);
        chk({v.name, " idle stall"}, {31'b0, stall_o}, 32'd0);
    endtask

    initial begin
        vec_t v [14];
        vec_t rd10;
        int   n, dones, st;
        v[0]  = '{"st08",     1'b0, 1'b1, 32'h0000_0008, 32'hDEADBEEF, 3, 32'h0,         1'b0};
        v[1]  = '{"ld08",     1'b1, 1'b0, 32'h0000_0008, 32'h0,        3, 32'hDEADBEEF, 1'b0};
        v[2]  = '{"ld06mis",  1'b1, 1'b0, 32'h0000_0006, 32'h0,        3, 32'h0,         1'b1};
        v[3]  = '{"st0Amis",  1'b0, 1'b1, 32'h0000_000A, 32'h55555555, 3, 32'h0,         1'b1};
        v[4]  = '{"ld08keep", 1'b1, 1'b0, 32'h0000_0008, 32'h0,        3, 32'hDEADBEEF, 1'b0};
        v[5]  = '{"st00",     1'b0, 1'b1, 32'h0000_0000, 32'h00000A0A, 3, 32'hDEADBEEF, 1'b0};
        v[6]  = '{"st04",     1'b0, 1'b1, 32'h0000_0004, 32'h00000B0B, 3, 32'hDEADBEEF, 1'b0};
        v[7]  = '{"st408wrap",1'b0, 1'b1, 32'h0000_0408, 32'h0BADF00D, 3, 32'hDEADBEEF, 1'b0};
        v[8]  = '{"ld08wrap", 1'b1, 1'b0, 32'h0000_0008, 32'h0,        3, 32'h0BADF00D, 1'b0};
        v[9]  = '{"rdwr0C",   1'b1, 1'b1, 32'h0000_000C, 32'h00000077, 3, 32'h0BADF00D, 1'b0};
        v[10] = '{"ld0C",     1'b1, 1'b0, 32'h0000_000C, 32'h0,        3, 32'h00000077, 1'b0};
        v[11] = '{"st10",     1'b0, 1'b1, 32'h0000_0010, 32'hAAAA0010, 3, 32'h00000077, 1'b0};
        v[12] = '{"ld10",     1'b1, 1'b0, 32'h0000_0010, 32'h0,        3, 32'hAAAA0010, 1'b0};
        v[13] = '{"ldhigh",   1'b1, 1'b0, 32'h8000_0004, 32'h0,        3, 32'h00000B0B, 1'b0};
        rd10  = '{"ld10rst",  1'b1, 1'b0, 32'h0000_0010, 32'h0,        3, 32'hAAAA0010, 1'b0};

        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst stall", {31'b0, stall_o}, 32'd0);
        chk("rst data", data_o, 32'h0);
        chk("rst err", {31'b0, err_o}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;

`ifdef DMEM_POSTED_WRITE_EN
        @(posedge clk); #1;
        MemWrite_i = 1'b1; addr_i = 32'h20; write_data_i = 32'hCAFEF00D;
        @(negedge clk);
        chk("post st stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1;
        MemWrite_i = 1'b0; MemRead_i = 1'b1;
        st = 0;
        @(negedge clk);
        while (stall_o === 1'b1 && st < 30) begin
            st++;
            @(negedge clk);
        end
        chk("post ld stalls", 32'(st), 32'd6);
        chk("post ld data", data_o, 32'hCAFEF00D);
        @(posedge clk); #1;
        MemRead_i = 1'b0;
        @(negedge clk);
        chk("post idle stall", {31'b0, stall_o}, 32'd0);
`else
        for (int i = 0; i < 14; i++) access(v[i]);

        // Back-to-back loads: the second address appears right after the first DONE.
        @(posedge clk); #1;
        MemRead_i = 1'b1; addr_i = 32'h0;
        n = 0;
        dones = 0;
        while (dones < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (stall_o === 1'b0) begin
                dones++;
                chk(dones == 1 ? "b2b data0" : "b2b data1", data_o,
                    dones == 1 ? 32'h00000A0A : 32'h00000B0B);
                @(posedge clk); #1;
                addr_i = 32'h4;
                if (dones == 2) MemRead_i = 1'b0;
            end
        end
        chk("b2b cycles", 32'(n), 32'd8);

        // Reset during the second BUSY cycle of a store must drop the store.
        @(posedge clk); #1;
        MemWrite_i = 1'b1; addr_i = 32'h10; write_data_i = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b1; MemWrite_i = 1'b0;
        @(negedge clk);
        chk("busy2 stall", {31'b0, stall_o}, 32'd1);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("midrst stall", {31'b0, stall_o}, 32'd0);
        chk("midrst data", data_o, 32'h0);
        chk("midrst err", {31'b0, err_o}, 32'd0);
        access(rd10);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder on the pipeline's MEM-stage load/store interface. The pipeline issues MemRead_i/MemWrite_i with address and store data from EX/MEM. This block services each request after a fixed latency and asserts stall_o to freeze the pipeline until the access completes. It replaces the single-cycle data memory and gives the pipeline's hazard/stall logic a real wait-state source.

## Interface
- DEPTH_WORDS, default 256: number of 32-bit words in the array; must be a power of two.
- LATENCY, default 3: request-to-completion latency in cycles; must be ≥1.
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_i, input, 1: synchronous, active-high reset.
- addr_i, input, 32: byte address of the access.
- write_data_i, input, 32: store data.
- MemRead_i, input, 1: load request.
- MemWrite_i, input, 1: store request; takes priority if both request lines are high.
- data_o, output, 32: load result register.
- stall_o, output, 1: pipeline freeze; combinational from state and request inputs.
- err_o, output, 1: misaligned-access flag; one-cycle pulse.

## Operation
- States: IDLE, BUSY, DONE. Under DMEM_POSTED_WRITE_EN there is also a DRAIN state (see Configuration).
- IDLE:
  - A request is MemRead_i or MemWrite_i high.
  - On a request: latch address, data and type; load the counter with LATENCY-1.
  - If LATENCY=1, go straight to DONE; otherwise go to BUSY.
  - stall_o = request present.
- BUSY:
  - stall_o=1; the counter decrements each cycle.
  - When the counter reaches 1, go to DONE on the next edge.
  - The memory action happens on the edge entering DONE:
    - Write: mem[index] ← latched data.
    - Read: data_o ← mem[index].
- DONE:
  - stall_o=0, so the pipeline advances at the end of this cycle.
  - Request inputs are ignored, because they still reflect the instruction just served.
  - Unconditionally return to IDLE.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so out-of-range addresses wrap.
- Misaligned access (addr[1:0]≠0):
  - The full latency is still taken.
  - The write is suppressed; a read loads data_o with 0.
  - err_o=1 during the DONE cycle only.
- data_o holds its value except on a read completion. Writes never change data_o.
- Reset:
  - Any state → IDLE; stall_o=0, data_o=0, err_o=0, counter=0.
  - An in-flight access is discarded; a pending write is never committed.
  - Array contents are not altered by reset.

## Timing
- Request present at IDLE cycle T:
  - stall_o high in cycles T … T+LATENCY-1.
  - DONE is cycle T+LATENCY; stall_o low there.
  - Load data is valid on data_o from T+LATENCY.
- LATENCY=1: stall_o high only in cycle T; DONE at T+1.
- Back-to-back requests: the next request is accepted at T+LATENCY+1 (IDLE). That gives a steady-state throughput of one access per LATENCY+1 cycles.
- Reset values: stall_o=0, data_o=32'h0, err_o=0.
- Requestor rule: addr_i, write_data_i and the request lines stay stable while stall_o=1. The block captures them in cycle T regardless.

## Configuration
- Macro DMEM_POSTED_WRITE_EN.
- Defined — aligned writes are posted:
  - A write in IDLE is captured into a one-entry write buffer with stall_o=0, and the state goes to DRAIN.
  - DRAIN commits the buffer after LATENCY cycles, then returns to IDLE.
  - Any new request during DRAIN sees stall_o=1 until the state returns to IDLE, then is handled normally.
  - Because of this, a read-after-write always observes the new data.
  - Misaligned writes are not posted; they follow the normal path with err_o.
- Undefined: no write buffer and no DRAIN state; writes stall exactly like reads.

## Test plan
- Reset: assert rst_i for 2 cycles → stall_o=0, data_o=0, err_o=0; first request after release is serviced normally.
- LATENCY=3, store 32'hDEADBEEF to 0x08, then load 0x08 (macro undefined):
  - Each access has 3 stall cycles.
  - data_o=32'hDEADBEEF in the load's DONE cycle.
- Misaligned load from 0x06 → 3 stall cycles; err_o=1 for exactly the DONE cycle; data_o=0. Misaligned store to 0x0A leaves mem[2] unchanged.
- Back-to-back loads 0x00, 0x04 → second request accepted the cycle after the first DONE; total 8 cycles for both at LATENCY=3.
- rst_i asserted in the 2nd BUSY cycle of a store of 32'h12345678 to 0x10 → stall_o=0 the next cycle; a later load of 0x10 returns its prior value.
- Macro defined, LATENCY=3: store 32'hCAFEF00D to 0x20, then immediate load 0x20:
  - The store shows no stall.
  - The load stalls for the remaining drain cycles plus 3.
  - data_o=32'hCAFEF00D.
